// File: rtl/bike_pkg.sv
// Shared definitions for the bike motion engine: orientation codes, FSM
// states, screen geometry and the linear pixel address helper.
package bike_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } orient_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int COORD_W     = 10;
  localparam int ADDR_W      = 19;
  localparam int BOOST_TICKS = 32;

  // y*640 + x without a multiplier: 640 = 512 + 128.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 9) + (yw << 7) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/bike_unit.sv
// One bike: position, orientation, pending turn request, dead flag and
// (when BIKE_BOOST_EN is defined) the one-shot speed boost.
module bike_unit
  import bike_pkg::*;
#(
  parameter int               STEP    = 2,
  parameter int               SPRITE  = 30,
  parameter logic [COORD_W-1:0] START_X = '0,
  parameter logic [COORD_W-1:0] START_Y = '0,
  parameter logic [1:0]       START_O = RIGHT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               run_en,
  input  logic               step_en,
  input  logic               crash,
  input  logic               req_valid,
  input  logic [1:0]         req_dir,
`ifdef BIKE_BOOST_EN
  input  logic               boost,
`endif
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [1:0]         orient,
  output logic               dead
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - SPRITE);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - SPRITE);

  logic               pend_valid;
  logic [1:0]         pend_dir;
  logic               req_ok;
  logic               crash_hit;
  logic               moving;
  logic [1:0]         next_o;
  logic [COORD_W-1:0] step_amt;
  logic [COORD_W-1:0] nx, ny;
  logic [COORD_W:0]   x_up, y_up;

`ifdef BIKE_BOOST_EN
  logic       boost_used;
  logic [5:0] boost_left;

  assign step_amt = (boost_left != '0) ? COORD_W'(2 * STEP) : COORD_W'(STEP);

  // One boost per round: arm the tick budget, then burn one per move.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      boost_used <= 1'b0;
      boost_left <= '0;
    end else if (load) begin
      boost_used <= 1'b0;
      boost_left <= '0;
    end else if (run_en && boost && !dead && !crash && !boost_used) begin
      boost_used <= 1'b1;
      boost_left <= 6'(BOOST_TICKS);
    end else if (moving && boost_left != '0) begin
      boost_left <= boost_left - 6'd1;
    end
  end
`else
  assign step_amt = COORD_W'(STEP);
`endif

  // Turn filtering, new orientation and clamped next position.
  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_ok    = req_valid && (req_dir != (orient ^ 2'b10));
    crash_hit = run_en && crash;
    moving    = step_en && !dead && !crash_hit;
    next_o    = orient;
    if (req_ok)          next_o = req_dir;
    else if (pend_valid) next_o = pend_dir;
    x_up = {1'b0, x} + {1'b0, step_amt};
    y_up = {1'b0, y} + {1'b0, step_amt};
    nx   = x;
    ny   = y;
    case (next_o)
      UP:      ny = (y < step_amt) ? '0 : y - step_amt;
      RIGHT:   nx = (x_up > {1'b0, X_MAX}) ? X_MAX : x_up[COORD_W-1:0];
      DOWN:    ny = (y_up > {1'b0, Y_MAX}) ? Y_MAX : y_up[COORD_W-1:0];
      default: nx = (x < step_amt) ? '0 : x - step_amt;
    endcase
  end

  // Bike state: crash beats the tick; a tick consumes the pending turn.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x          <= START_X;
      y          <= START_Y;
      orient     <= START_O;
      dead       <= 1'b0;
      pend_valid <= 1'b0;
      pend_dir   <= '0;
    end else if (load) begin
      x          <= START_X;
      y          <= START_Y;
      orient     <= START_O;
      dead       <= 1'b0;
      pend_valid <= 1'b0;
      pend_dir   <= '0;
    end else begin
      if (req_ok) begin
        pend_valid <= 1'b1;
        pend_dir   <= req_dir;
      end
      if (crash_hit) begin
        dead <= 1'b1;
      end else if (moving) begin
        x          <= nx;
        y          <= ny;
        orient     <= next_o;
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bike_motion_engine.sv
// Round sequencer and movement tick generator for up to four bikes; drives
// the position/orientation words read by the VGA controller.
// Optional feature macro: BIKE_BOOST_EN adds the 4-bit `boost` input.
module bike_motion_engine
  import bike_pkg::*;
#(
  parameter int         TICK_CYCLES = 833333,
  parameter int         STEP        = 2,
  parameter int         SPRITE      = 30,
  parameter int         START_X1    = 100,
  parameter int         START_Y1    = 100,
  parameter int         START_X2    = 510,
  parameter int         START_Y2    = 350,
  parameter int         START_X3    = 510,
  parameter int         START_Y3    = 100,
  parameter int         START_X4    = 100,
  parameter int         START_Y4    = 350,
  parameter logic [1:0] START_O1    = RIGHT,
  parameter logic [1:0] START_O2    = LEFT,
  parameter logic [1:0] START_O3    = LEFT,
  parameter logic [1:0] START_O4    = RIGHT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        four_player_mode,
  input  logic [7:0]  dir_req,
  input  logic [3:0]  dir_req_valid,
  input  logic [3:0]  crash,
`ifdef BIKE_BOOST_EN
  input  logic [3:0]  boost,
`endif
  output logic [31:0] bikeone,
  output logic [31:0] biketwo,
  output logic [31:0] bikethree,
  output logic [31:0] bikefour,
  output logic [31:0] bikeoneOrient,
  output logic [31:0] biketwoOrient,
  output logic [31:0] bikethreeOrient,
  output logic [31:0] bikefourOrient,
  output logic        tick,
  output logic        reset_map,
  output logic        game_over,
  output logic [2:0]  winner
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int         SX [4] = '{START_X1, START_X2, START_X3, START_X4};
  localparam int         SY [4] = '{START_Y1, START_Y2, START_Y3, START_Y4};
  localparam logic [1:0] SO [4] = '{START_O1, START_O2, START_O3, START_O4};

  state_t             state;
  logic               start_q;
  logic               mode_q;
  logic [CNT_W-1:0]   counter;
  logic               run, load, start_rise, tick_fire;
  logic [3:0]         active, crash_eff, live_next, dead_w;
  logic [2:0]         live_cnt, winner_next;
  logic [COORD_W-1:0] x_w [4];
  logic [COORD_W-1:0] y_w [4];
  logic [1:0]         o_w [4];

  // Round control decode: tick timing, active set and round-end test.
  always_comb begin
    run         = (state == S_RUN);
    start_rise  = start && !start_q;
    load        = start_rise && !run;
    tick_fire   = run && (counter == CNT_W'(TICK_CYCLES - 1));
    active      = mode_q ? 4'b1111 : 4'b0011;
    crash_eff   = crash & active & {4{run}};
    live_next   = active & ~(dead_w | crash_eff);
    live_cnt    = {2'b0, live_next[0]} + {2'b0, live_next[1]}
                + {2'b0, live_next[2]} + {2'b0, live_next[3]};
    winner_next = 3'd0;
    if (live_cnt == 3'd1) begin
      if (live_next[0])      winner_next = 3'd1;
      else if (live_next[1]) winner_next = 3'd2;
      else if (live_next[2]) winner_next = 3'd3;
      else                   winner_next = 3'd4;
    end
  end

  // Round FSM with registered tick, reset_map, game_over and winner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      mode_q    <= 1'b0;
      counter   <= '0;
      tick      <= 1'b0;
      reset_map <= 1'b0;
      game_over <= 1'b0;
      winner    <= 3'd0;
    end else begin
      start_q   <= start;
      tick      <= tick_fire;
      reset_map <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start_rise) begin
            state     <= S_RUN;
            mode_q    <= four_player_mode;
            counter   <= '0;
            reset_map <= 1'b1;
            game_over <= 1'b0;
            winner    <= 3'd0;
          end
        end
        S_RUN: begin
          counter <= tick_fire ? '0 : counter + CNT_W'(1);
          if (live_cnt <= 3'd1) begin
            state     <= S_OVER;
            game_over <= 1'b1;
            winner    <= winner_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bike
    bike_unit #(
      .STEP    (STEP),
      .SPRITE  (SPRITE),
      .START_X (COORD_W'(SX[g])),
      .START_Y (COORD_W'(SY[g])),
      .START_O (SO[g])
    ) u_bike (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .run_en    (run && active[g]),
      .step_en   (tick_fire && active[g]),
      .crash     (crash[g]),
      .req_valid (dir_req_valid[g]),
      .req_dir   (dir_req[2*g +: 2]),
`ifdef BIKE_BOOST_EN
      .boost     (boost[g]),
`endif
      .x         (x_w[g]),
      .y         (y_w[g]),
      .orient    (o_w[g]),
      .dead      (dead_w[g])
    );
  end

  assign bikeone         = {13'd0, addr_of(x_w[0], y_w[0])};
  assign biketwo         = {13'd0, addr_of(x_w[1], y_w[1])};
  assign bikethree       = {13'd0, addr_of(x_w[2], y_w[2])};
  assign bikefour        = {13'd0, addr_of(x_w[3], y_w[3])};
  assign bikeoneOrient   = {30'd0, o_w[0]};
  assign biketwoOrient   = {30'd0, o_w[1]};
  assign bikethreeOrient = {30'd0, o_w[2]};
  assign bikefourOrient  = {30'd0, o_w[3]};

endmodule

// File: tb/tb_bike_motion_engine.sv
// Scoreboard bench for bike_motion_engine (TICK_CYCLES=4, STEP=2).
// Stimulus pushes expected snapshots; a negedge monitor pops and compares on
// every reset_map pulse, tick pulse and game_over rising edge.
module tb_bike_motion_engine;

  logic        clock = 1'b0;
  logic        reset, start, four_player_mode;
  logic [7:0]  dir_req;
  logic [3:0]  dir_req_valid, crash;
  logic [31:0] bikeone, biketwo, bikethree, bikefour;
  logic [31:0] bikeoneOrient, biketwoOrient, bikethreeOrient, bikefourOrient;
  logic        tick, reset_map, game_over;
  logic [2:0]  winner;
`ifdef BIKE_BOOST_EN
  logic [3:0]  boost = 4'd0;
`endif

  always #5 clock = ~clock;

  bike_motion_engine #(.TICK_CYCLES(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .four_player_mode(four_player_mode),
    .dir_req         (dir_req),
    .dir_req_valid   (dir_req_valid),
    .crash           (crash),
`ifdef BIKE_BOOST_EN
    .boost           (boost),
`endif
    .bikeone         (bikeone),
    .biketwo         (biketwo),
    .bikethree       (bikethree),
    .bikefour        (bikefour),
    .bikeoneOrient   (bikeoneOrient),
    .biketwoOrient   (biketwoOrient),
    .bikethreeOrient (bikethreeOrient),
    .bikefourOrient  (bikefourOrient),
    .tick            (tick),
    .reset_map       (reset_map),
    .game_over       (game_over),
    .winner          (winner)
  );

  typedef struct packed {
    logic [3:0][31:0] pos;
    logic [3:0][31:0] ori;
    logic [2:0]       win;
  } exp_t;

  exp_t map_q[$], tick_q[$], over_q[$];
  int   n_total = 0, n_pass = 0, map_seen = 0;
  int   mx[4], my[4], mo[4];
  bit   m_act[4], m_dead[4];
  int   sx[4] = '{100, 510, 510, 100};
  int   sy[4] = '{100, 350, 100, 350};
  int   so[4] = '{1, 3, 3, 1};
  logic go_q = 1'b0;
  logic [3:0][31:0] act_pos, act_ori;

  assign act_pos = {bikefour, bikethree, biketwo, bikeone};
  assign act_ori = {bikefourOrient, bikethreeOrient, biketwoOrient, bikeoneOrient};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic exp_t snap(input logic [2:0] w);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.pos[i] = 32'(my[i] * 640 + mx[i]);
      e.ori[i] = 32'(mo[i]);
    end
    e.win = w;
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input bit with_win);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s bike%0d pos", tag, i + 1), act_pos[i], e.pos[i]);
      check($sformatf("%s bike%0d orient", tag, i + 1), act_ori[i], e.ori[i]);
    end
    if (with_win) check($sformatf("%s winner", tag), 32'(winner), 32'(e.win));
  endtask

  // Monitor: pop an expectation whenever the DUT presents an event.
  always @(negedge clock) begin
    if (reset_map) begin
      map_seen++;
      check("reset_map expected", 32'(map_q.size() != 0), 32'd1);
      if (map_q.size() != 0) cmp("map", map_q.pop_front(), 1'b0);
    end
    if (tick) begin
      check("tick expected", 32'(tick_q.size() != 0), 32'd1);
      if (tick_q.size() != 0) cmp("tick", tick_q.pop_front(), 1'b0);
    end
    if (game_over && !go_q) begin
      check("game_over expected", 32'(over_q.size() != 0), 32'd1);
      if (over_q.size() != 0) cmp("over", over_q.pop_front(), 1'b1);
    end
    go_q = game_over;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_tick();
    for (int i = 0; i < 4; i++) begin
      if (m_act[i] && !m_dead[i]) begin
        case (mo[i])
          0:       my[i] = (my[i] < 2) ? 0 : my[i] - 2;
          1:       mx[i] = (mx[i] > 608) ? 610 : mx[i] + 2;
          2:       my[i] = (my[i] > 448) ? 450 : my[i] + 2;
          default: mx[i] = (mx[i] < 2) ? 0 : mx[i] - 2;
        endcase
      end
    end
    tick_q.push_back(snap(3'd0));
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clock);
      seen = tick;
    end
    check("tick within budget", 32'(seen), 32'd1);
  endtask

  task automatic round_start(input bit mode);
    bit seen = 1'b0;
    four_player_mode = mode;
    for (int i = 0; i < 4; i++) begin
      mx[i] = sx[i]; my[i] = sy[i]; mo[i] = so[i];
      m_dead[i] = 1'b0;
      m_act[i]  = (i < 2) || mode;
    end
    map_q.push_back(snap(3'd0));
    start = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clock);
      seen = reset_map;
    end
    check("reset_map within budget", 32'(seen), 32'd1);
    start = 1'b0;
  endtask

  task automatic req(input int b, input logic [1:0] d);
    dir_req = '0;
    dir_req[2*b +: 2] = d;
    dir_req_valid = 4'(1 << b);
    @(negedge clock);
    dir_req_valid = '0;
  endtask

  task automatic pulse_crash(input logic [3:0] m);
    crash = m;
    @(negedge clock);
    crash = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; four_player_mode = 1'b0;
    dir_req = '0; dir_req_valid = '0; crash = '0;
    cyc(3);
    check("rst bikeone", bikeone, 32'd64100);
    check("rst biketwo", biketwo, 32'd224510);
    check("rst bikethree", bikethree, 32'd64510);
    check("rst bikefour", bikefour, 32'd224100);
    check("rst orient1", bikeoneOrient, 32'd1);
    check("rst orient2", biketwoOrient, 32'd3);
    check("rst orient3", bikethreeOrient, 32'd3);
    check("rst orient4", bikefourOrient, 32'd1);
    check("rst tick", 32'(tick), 32'd0);
    check("rst reset_map", 32'(reset_map), 32'd0);
    check("rst game_over", 32'(game_over), 32'd0);
    check("rst winner", 32'(winner), 32'd0);
    reset = 1'b0;
    cyc(2);

    // Round 1: two players, turns, saturation, crash of bike 2.
    round_start(1'b0);
    push_tick(); wait_tick();
    check("first tick bikeone", bikeone, 32'd64102);
    req(0, 2'd0); mo[0] = 0;
    push_tick(); wait_tick();
    check("turn up bikeone", bikeone, 32'd62822);
    check("turn up orient", bikeoneOrient, 32'd0);
    req(0, 2'd1); mo[0] = 1;
    push_tick(); wait_tick();
    req(0, 2'd3);
    push_tick(); wait_tick();
    check("reverse ignored orient", bikeoneOrient, 32'd1);
    req(0, 2'd2); req(0, 2'd1);
    push_tick(); wait_tick();
    pulse_crash(4'b0100);
    push_tick(); wait_tick();
    for (int k = 0; k < 400 && mx[0] < 610; k++) begin
      push_tick(); wait_tick();
    end
    check("x saturates at 610", bikeone, 32'd63330);
    repeat (3) begin push_tick(); wait_tick(); end
    check("x holds at 610", bikeone, 32'd63330);
    m_dead[1] = 1'b1;
    over_q.push_back(snap(3'd1));
    pulse_crash(4'b0010);
    cyc(8);
    check("frozen biketwo", biketwo, 32'(my[1] * 640 + mx[1]));
    check("game_over held", 32'(game_over), 32'd1);
    check("map pulses round1", 32'(map_seen), 32'd1);

    // Round 2: four players, crash on a tick, then everyone crashes at once.
    round_start(1'b1);
    push_tick(); wait_tick();
    cyc(3);
    crash = 4'b0001; m_dead[0] = 1'b1;
    push_tick();
    @(negedge clock);
    crash = '0;
    check("tick with crash", 32'(tick), 32'd1);
    check("crashed bike held", bikeone, 32'd64102);
    push_tick(); wait_tick();
    for (int i = 0; i < 4; i++) m_dead[i] = 1'b1;
    over_q.push_back(snap(3'd0));
    pulse_crash(4'b1111);
    cyc(3);

    // Round 3: restart restores bikes; start edge during RUN is ignored.
    round_start(1'b0);
    push_tick(); wait_tick();
    check("restart bikeone moves", bikeone, 32'd64102);
    push_tick();
    start = 1'b1; cyc(1); start = 1'b0;
    wait_tick();
    m_dead[0] = 1'b1;
    over_q.push_back(snap(3'd2));
    pulse_crash(4'b0001);
    cyc(3);
    check("winner bike2", 32'(winner), 32'd2);

    check("map pulses total", 32'(map_seen), 32'd3);
    check("map queue drained", 32'(map_q.size()), 32'd0);
    check("tick queue drained", 32'(tick_q.size()), 32'd0);
    check("over queue drained", 32'(over_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bike_motion_engine.md
Name: bike_motion_engine

Overview:
- Producer side of the bike position/orientation interface consumed by the VGA controller.
- Holds each bike's sprite top-left pixel address (linear, 640 px/row) and orientation word.
- Advances every bike once per game tick, applies player turn requests, and freezes bikes the VGA side flags as crashed.
- Sequences a round (idle, run, over), pulses `reset_map` at round start and reports the winner.

Parameters:
- TICK_CYCLES, 833333 — clock cycles per movement tick (~60 Hz at 50 MHz).
- STEP, 2 — pixels moved per tick.
- SPRITE, 30 — sprite edge in pixels; positions are clamped to 0..640-SPRITE (x) and 0..480-SPRITE (y).
- START_X1/Y1..START_X4/Y4, (100,100),(510,350),(510,100),(100,350) — start corners.
- START_O1..START_O4, RIGHT, LEFT, LEFT, RIGHT — start orientations.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  level; a rising edge begins a round from IDLE or OVER
- four_player_mode  in  1  sampled at round start; 0 = bikes 1-2 only
- dir_req  in  8  2-bit requested direction per bike, bike1 = [1:0]
- dir_req_valid  in  4  one bit per bike; qualifies dir_req that cycle
- crash  in  4  bikeone_crash..bikefour_crash from the VGA controller
- bikeone, biketwo, bikethree, bikefour  out  32 each  y*640+x, upper 13 bits zero
- bikeoneOrient..bikefourOrient  out  32 each  orientation code in [1:0], rest zero
- tick  out  1  one-cycle pulse when positions update
- reset_map  out  1  one-cycle pulse on round start
- game_over  out  1  high in OVER
- winner  out  3  1..4 = winning bike, 0 = draw/none

Behaviour:
- Orientation codes: UP=0, RIGHT=1, DOWN=2, LEFT=3.
- Reset values (async, immediate):
  - state=IDLE, tick=0, reset_map=0, game_over=0, winner=0, dead=0, counter=0.
  - Positions and orientations hold their START_* values.
- FSM IDLE:
  - On a `start` rising edge (registered edge detect): load START_*, clear dead, latch four_player_mode.
  - Pulse reset_map on the next cycle, counter=0, go to RUN.
- FSM RUN:
  - The counter wraps at TICK_CYCLES-1; tick fires the cycle after the wrap.
  - Each position and orientation update is registered on the tick cycle, so outputs change exactly at tick.
- FSM OVER: outputs frozen, game_over=1; a `start` edge restarts exactly as from IDLE.
- Turn requests:
  - A valid request is stored in a per-bike pending register; the last request before a tick wins.
  - Applied at the tick, then the pending register clears.
  - A request equal to the reverse of the current orientation (code XOR 2) is discarded on arrival.
  - A request equal to the current orientation is a no-op.
- Movement at tick, for live bikes only, using the new orientation:
  - UP: y-=STEP; DOWN: y+=STEP; LEFT: x-=STEP; RIGHT: x+=STEP.
  - Saturate at 0 and at the max coordinate; no wrap.
  - Address = y*640+x, computed with shifts and adds (y<<9 + y<<7 + x), 19-bit result zero-extended.
- Crash handling:
  - crash[i] is sampled every cycle in RUN. When high, dead[i] is set and stays set until the next round start.
  - Dead bikes hold position and orientation.
  - crash is ignored outside RUN.
  - crash for bikes 3-4 is ignored when four_player_mode=0.
- Round end:
  - Evaluated every RUN cycle after the dead update.
  - Live count ≤1 among active bikes → OVER next cycle.
  - winner = index of the sole live bike; 0 if all active bikes died in the same cycle.
- Simultaneous events:
  - A crash and a tick in the same cycle: the crash wins and that bike does not move.
  - A start edge during RUN is ignored.
- Inactive bikes (3-4 in two-player mode) stay at their start values.

Optional Feature:
- Macro: BIKE_BOOST_EN.
- With the macro defined:
  - Extra input `boost` (4 bits).
  - A boost pulse on a live bike gives 2*STEP per tick for 32 ticks.
  - One boost per bike per round; extra pulses are ignored.
  - The boost-remaining counters reset at round start.
- Without the macro: no `boost` port; the step is always STEP.

Decomposition:
- Package `bike_pkg` holds:
  - orientation codes UP/RIGHT/DOWN/LEFT;
  - screen constants SCREEN_W=640, SCREEN_H=480;
  - the `addr_of(x,y)` function.
- Sub-module `bike_unit` is instantiated 4 times. It holds one bike's x/y, orientation, pending request, dead flag and boost state, driven by common tick/load/enable signals.
- The top level holds the FSM, tick counter, start edge detect, live count and winner encoder.

Test Plan (TICK_CYCLES=4, STEP=2):
- Reset, then a start edge → reset_map pulses once; bikeone=64100 (100*640+100), bikeoneOrient=1; first tick → bikeone=64102.
- Bike1 request UP (dir_req[1:0]=0) between ticks → next tick bikeoneOrient=0, bikeone=64102-1280=62822; a LEFT request while orient=RIGHT → ignored, orientation stays 1.
- Bike1 at x=608 moving RIGHT → x saturates at 610 and holds on further ticks with no wraparound.
- Two-player mode, crash=4'b0010 for one cycle → biketwo freezes, game_over=1 next cycle, winner=1; crash[2]=1 in two-player mode → no effect.
- Four-player mode, crash=4'b1111 in one cycle → OVER, winner=0; a new start edge → all bikes back at start, dead cleared.
- Crash and tick in the same cycle for bike1 → bikeone unchanged; with BIKE_BOOST_EN, a boost pulse → +4 px/tick for 32 ticks, then +2.
